// File: rtl/blake2_msg_loader.sv
// blake2_msg_loader
// Feeds the blake2 core's byte-load port from a valid/ready byte stream.
// Key bytes (if any) form the first block and are zero-padded to a full
// block. Message bytes follow, and the final block is zero-padded. After
// each non-final block the stream is held off for the core's compression
// latency. The loader stays busy until the core has streamed its digest.
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | waiting for start_i; ll/kk/nn hold their last values
// KEY      | accepting key bytes into the first block
// MSG      | accepting message bytes, one beat per accepted byte
// PAD      | emitting zero beats back-to-back up to the end of the block
// GAP      | stream held off while the core compresses a non-final block
// WAIT_RES | final block loaded; waiting for finished to rise then fall
module blake2_msg_loader #(
    parameter int BLOCK_BYTES = 64,
    parameter int IDX_W       = $clog2(BLOCK_BYTES),
    parameter int LL_W        = 128,
    parameter int KK_W        = 7,
    parameter int GAP_CYCLES  = 105
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_i,
    input  logic             empty_i,
    input  logic [KK_W-1:0]  kk_i,
    input  logic [KK_W-1:0]  nn_i,
    input  logic             s_valid_i,
    input  logic [7:0]       s_data_i,
    input  logic             s_last_i,
    output logic             s_ready_o,
    input  logic             core_finished_i,
    output logic             data_v_o,
    output logic [IDX_W-1:0] data_idx_o,
    output logic [7:0]       data_o,
    output logic             block_first_o,
    output logic             block_last_o,
    output logic [LL_W-1:0]  ll_o,
    output logic [KK_W-1:0]  kk_o,
    output logic [KK_W-1:0]  nn_o,
    output logic             busy_o
);

    typedef enum logic [2:0] {
        IDLE,
        KEY,
        MSG,
        PAD,
        GAP,
        WAIT_RES
    } state_t;

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(BLOCK_BYTES - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [KK_W-1:0]  KK_FULL  = KK_W'(BLOCK_BYTES);
    localparam logic [KK_W-1:0]  KK_ONE   = KK_W'(1);
    localparam logic [LL_W-1:0]  LL_BLOCK = LL_W'(BLOCK_BYTES);
    localparam logic [LL_W-1:0]  LL_ONE   = LL_W'(1);
    localparam int               GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES - 1);
    localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);

    state_t           state;
    logic [IDX_W-1:0] idx_cnt;
    logic [GAP_W-1:0] gap_cnt;
    logic             fin_seen;
    logic [KK_W-1:0]  kk_sat;
    logic             accept;
    logic             at_block_end;
    logic             key_done;

    // A key longer than one block is clamped so it always fits in block 0
    always_comb begin
        kk_sat = kk_i;
        if (kk_i > KK_FULL) begin
            kk_sat = KK_FULL;
        end
    end

    assign s_ready_o    = (state == KEY) || (state == MSG);
    assign busy_o       = (state != IDLE);
    assign accept       = s_valid_i && s_ready_o;
    assign at_block_end = (idx_cnt == IDX_LAST);
    assign key_done     = (KK_W'(idx_cnt) == (kk_o - KK_ONE));

    // Sequencer: block framing, beat generation, byte count and block flags.
    // idx_cnt is the index the next beat will carry; data_idx_o is the
    // index of the beat currently on the port and holds across stalls.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            idx_cnt       <= '0;
            gap_cnt       <= '0;
            fin_seen      <= 1'b0;
            data_v_o      <= 1'b0;
            data_idx_o    <= '0;
            data_o        <= '0;
            block_first_o <= 1'b0;
            block_last_o  <= 1'b0;
            ll_o          <= '0;
            kk_o          <= '0;
            nn_o          <= '0;
        end else begin
            data_v_o <= 1'b0;

            // the first block ends once its last beat has been presented
            if (data_v_o && (data_idx_o == IDX_LAST)) begin
                block_first_o <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (start_i) begin
                        kk_o          <= kk_sat;
                        nn_o          <= nn_i;
                        ll_o          <= '0;
                        idx_cnt       <= '0;
                        fin_seen      <= 1'b0;
                        block_first_o <= 1'b1;
                        // an empty message makes the very first block final
                        block_last_o  <= empty_i;
                        if (kk_sat != '0) begin
                            state <= KEY;
                        end else if (empty_i) begin
                            state <= PAD;
                        end else begin
                            state <= MSG;
                        end
                    end
                end

                KEY: begin
                    if (accept) begin
                        data_v_o   <= 1'b1;
                        data_idx_o <= idx_cnt;
                        data_o     <= s_data_i;
                        idx_cnt    <= idx_cnt + IDX_ONE;
                        if (key_done) begin
                            if (kk_o == KK_FULL) begin
                                // key fills the block exactly: no pad needed
                                ll_o    <= ll_o + LL_BLOCK;
                                gap_cnt <= GAP_LOAD;
                                state   <= block_last_o ? WAIT_RES : GAP;
                            end else begin
                                state <= PAD;
                            end
                        end
                    end
                end

                MSG: begin
                    if (accept) begin
                        data_v_o   <= 1'b1;
                        data_idx_o <= idx_cnt;
                        data_o     <= s_data_i;
                        idx_cnt    <= idx_cnt + IDX_ONE;
                        ll_o       <= ll_o + LL_ONE;
                        if (s_last_i) begin
                            block_last_o <= 1'b1;
                        end
                        if (at_block_end) begin
                            gap_cnt <= GAP_LOAD;
                            state   <= (block_last_o || s_last_i) ? WAIT_RES : GAP;
                        end else if (s_last_i) begin
                            state <= PAD;
                        end
                    end
                end

                PAD: begin
                    data_v_o   <= 1'b1;
                    data_idx_o <= idx_cnt;
                    data_o     <= 8'h00;
                    idx_cnt    <= idx_cnt + IDX_ONE;
                    if (at_block_end) begin
                        // a padded key block still counts as a full block
                        if (block_first_o && (kk_o != '0)) begin
                            ll_o <= ll_o + LL_BLOCK;
                        end
                        gap_cnt <= GAP_LOAD;
                        state   <= block_last_o ? WAIT_RES : GAP;
                    end
                end

                GAP: begin
                    if (gap_cnt == '0) begin
                        state <= MSG;
                    end else begin
                        gap_cnt <= gap_cnt - GAP_ONE;
                    end
                end

                WAIT_RES: begin
                    if (core_finished_i) begin
                        fin_seen <= 1'b1;
                    end else if (fin_seen) begin
                        fin_seen      <= 1'b0;
                        block_first_o <= 1'b0;
                        block_last_o  <= 1'b0;
                        state         <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_blake2_msg_loader.sv
// Testbench for blake2_msg_loader: randomized streams compared beat by beat
// against an expected block image built from the framing rules.
module tb_blake2_msg_loader;

    localparam int BLOCK_BYTES = 64;
    localparam int IDX_W       = 6;
    localparam int LL_W        = 128;
    localparam int KK_W        = 7;
    localparam int GAP_CYCLES  = 105;

    logic             clk = 1'b0;
    logic             reset;
    logic             start_i;
    logic             empty_i;
    logic [KK_W-1:0]  kk_i;
    logic [KK_W-1:0]  nn_i;
    logic             s_valid_i;
    logic [7:0]       s_data_i;
    logic             s_last_i;
    logic             s_ready_o;
    logic             core_finished_i;
    logic             data_v_o;
    logic [IDX_W-1:0] data_idx_o;
    logic [7:0]       data_o;
    logic             block_first_o;
    logic             block_last_o;
    logic [LL_W-1:0]  ll_o;
    logic [KK_W-1:0]  kk_o;
    logic [KK_W-1:0]  nn_o;
    logic             busy_o;

    int         n_checks = 0;
    int         n_errors = 0;
    logic [7:0] msg_q[$];

    always #5 clk = ~clk;

    blake2_msg_loader #(
        .BLOCK_BYTES(BLOCK_BYTES),
        .IDX_W      (IDX_W),
        .LL_W       (LL_W),
        .KK_W       (KK_W),
        .GAP_CYCLES (GAP_CYCLES)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .start_i        (start_i),
        .empty_i        (empty_i),
        .kk_i           (kk_i),
        .nn_i           (nn_i),
        .s_valid_i      (s_valid_i),
        .s_data_i       (s_data_i),
        .s_last_i       (s_last_i),
        .s_ready_o      (s_ready_o),
        .core_finished_i(core_finished_i),
        .data_v_o       (data_v_o),
        .data_idx_o     (data_idx_o),
        .data_o         (data_o),
        .block_first_o  (block_first_o),
        .block_last_o   (block_last_o),
        .ll_o           (ll_o),
        .kk_o           (kk_o),
        .nn_o           (nn_o),
        .busy_o         (busy_o)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic fill_msg(input int n);
        msg_q.delete();
        repeat (n) msg_q.push_back(8'($urandom));
    endtask

    // Runs one message (key generated here, message from msg_q).
    // mode 0: always valid, 1: valid every other cycle, 2: random valid.
    task automatic run_msg(input int kk_in, input int nn, input int mode);
        int              kk_eff, mlen, nblk, last_from, limit;
        int              cyc, ptr, bi, gap_cnt, ready_hi, extra;
        bit              gap_on, prev_acc, v;
        logic [7:0]      flat[$];
        logic [7:0]      strm[$];
        logic [15:0]     exp_q[$];
        logic [LL_W-1:0] exp_ll;

        // expected block image: key block padded, message padded,
        // or a single zero block for an empty unkeyed message
        kk_eff = (kk_in > BLOCK_BYTES) ? BLOCK_BYTES : kk_in;
        mlen   = msg_q.size();
        for (int i = 0; i < kk_eff; i++) begin
            strm.push_back(8'($urandom));
            flat.push_back(strm[i]);
        end
        while (flat.size() % BLOCK_BYTES != 0) flat.push_back(8'h00);
        foreach (msg_q[i]) begin
            strm.push_back(msg_q[i]);
            flat.push_back(msg_q[i]);
        end
        while (flat.size() % BLOCK_BYTES != 0) flat.push_back(8'h00);
        if (flat.size() == 0) begin
            repeat (BLOCK_BYTES) flat.push_back(8'h00);
        end
        nblk = flat.size() / BLOCK_BYTES;
        if (mlen > 0) last_from = ((kk_eff > 0) ? BLOCK_BYTES : 0) + mlen - 1;
        else          last_from = (nblk - 1) * BLOCK_BYTES;
        for (int j = 0; j < flat.size(); j++) begin
            exp_q.push_back({(j < BLOCK_BYTES), (j >= last_from),
                             IDX_W'(j % BLOCK_BYTES), flat[j]});
        end
        exp_ll = LL_W'(mlen + ((kk_eff > 0) ? BLOCK_BYTES : 0));
        limit  = nblk * (3 * BLOCK_BYTES + GAP_CYCLES + 20) + 100;

        @(negedge clk);
        start_i = 1'b1;
        empty_i = (mlen == 0);
        kk_i    = KK_W'(kk_in);
        nn_i    = KK_W'(nn);
        @(negedge clk);
        start_i = 1'b0;
        empty_i = 1'b0;
        kk_i    = '0;
        nn_i    = '0;
        check("busy_after_start", 128'(busy_o), 128'(1));

        cyc = 0; ptr = 0; bi = 0; gap_cnt = 0; ready_hi = 0;
        gap_on = 1'b0; prev_acc = 1'b0;
        while (bi < exp_q.size() && cyc < limit) begin
            if (s_ready_o) ready_hi++;
            if (prev_acc) check("beat_latency", 128'(data_v_o), 128'(1));
            if (data_v_o) begin
                check($sformatf("beat%0d", bi),
                      128'({block_first_o, block_last_o, data_idx_o, data_o}),
                      128'(exp_q[bi]));
                if ((bi % BLOCK_BYTES == BLOCK_BYTES - 1) && (bi + 1 < exp_q.size())) begin
                    gap_on  = 1'b1;
                    gap_cnt = 0;
                end
                bi++;
            end
            if (gap_on) begin
                if (s_ready_o) begin
                    check("gap_len", 128'(gap_cnt), 128'(GAP_CYCLES));
                    gap_on = 1'b0;
                end else begin
                    gap_cnt++;
                end
            end

            // a start pulse mid-message must be ignored
            start_i = (cyc == 5);
            empty_i = (cyc == 5);
            kk_i    = (cyc == 5) ? KK_W'(3) : '0;
            nn_i    = (cyc == 5) ? KK_W'(1) : '0;

            case (mode)
                0:       v = (ptr < strm.size());
                1:       v = (ptr < strm.size()) && ((cyc % 2) == 0);
                default: v = (ptr < strm.size()) && ($urandom_range(0, 3) != 0);
            endcase
            s_valid_i = v;
            s_data_i  = v ? strm[ptr] : 8'($urandom);
            if (!v || ptr < kk_eff) s_last_i = 1'($urandom);
            else                    s_last_i = (ptr == strm.size() - 1);
            prev_acc = v && s_ready_o;
            if (prev_acc) ptr++;
            @(negedge clk);
            cyc++;
        end
        s_valid_i = 1'b0;
        s_last_i  = 1'b0;
        start_i   = 1'b0;
        empty_i   = 1'b0;
        kk_i      = '0;
        nn_i      = '0;

        check("beats_seen", 128'(bi), 128'(exp_q.size()));
        check("bytes_accepted", 128'(ptr), 128'(strm.size()));
        if (strm.size() == 0) check("ready_never", 128'(ready_hi), 128'(0));

        extra = 0;
        repeat (8) begin
            @(negedge clk);
            if (data_v_o) extra++;
        end
        check("extra_beats", 128'(extra), 128'(0));
        check("ll_final", 128'(ll_o), 128'(exp_ll));
        check("kk_o", 128'(kk_o), 128'(kk_eff));
        check("nn_o", 128'(nn_o), 128'(nn));
        check("busy_wait_res", 128'(busy_o), 128'(1));

        core_finished_i = 1'b1;
        repeat (3) @(negedge clk);
        core_finished_i = 1'b0;
        check("busy_while_finished", 128'(busy_o), 128'(1));
        @(negedge clk);
        check("busy_fall", 128'(busy_o), 128'(0));
        check("idle_ll_hold", 128'(ll_o), 128'(exp_ll));
        check("idle_no_beat", 128'(data_v_o), 128'(0));
    endtask

    // Aborts an unkeyed message with reset while beat idx 20 is on the port.
    task automatic run_reset_mid();
        int         ptr, cyc, beats;
        bit         found, v;
        logic [7:0] strm[$];

        repeat (40) strm.push_back(8'($urandom));
        @(negedge clk);
        start_i = 1'b1;
        empty_i = 1'b0;
        kk_i    = '0;
        nn_i    = KK_W'(32);
        @(negedge clk);
        start_i = 1'b0;
        nn_i    = '0;
        ptr = 0; cyc = 0; found = 1'b0;
        while (!found && cyc < 300) begin
            if (data_v_o && data_idx_o == IDX_W'(20)) begin
                found = 1'b1;
            end else begin
                v         = (ptr < strm.size());
                s_valid_i = v;
                s_data_i  = v ? strm[ptr] : 8'h00;
                s_last_i  = v && (ptr == strm.size() - 1);
                if (v && s_ready_o) ptr++;
                @(negedge clk);
                cyc++;
            end
        end
        check("rst_found_idx20", 128'(found), 128'(1));
        check("rst_ll_before", 128'(ll_o), 128'(21));
        reset = 1'b1;
        #1;
        check("rst_mid_ctl", 128'({data_v_o, s_ready_o, busy_o, block_first_o, block_last_o}), 128'(0));
        check("rst_mid_beat", 128'({data_idx_o, data_o}), 128'(0));
        check("rst_mid_ll", 128'(ll_o), 128'(0));
        check("rst_mid_kknn", 128'({kk_o, nn_o}), 128'(0));
        beats = 0;
        repeat (4) begin
            @(negedge clk);
            if (data_v_o) beats++;
        end
        check("rst_no_beats", 128'(beats), 128'(0));
        s_valid_i = 1'b0;
        s_last_i  = 1'b0;
        reset     = 1'b0;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset           = 1'b1;
        start_i         = 1'b0;
        empty_i         = 1'b0;
        kk_i            = '0;
        nn_i            = '0;
        s_valid_i       = 1'b0;
        s_data_i        = '0;
        s_last_i        = 1'b0;
        core_finished_i = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_ctl", 128'({data_v_o, s_ready_o, busy_o, block_first_o, block_last_o}), 128'(0));
        check("reset_beat", 128'({data_idx_o, data_o}), 128'(0));
        check("reset_ll", 128'(ll_o), 128'(0));
        check("reset_kknn", 128'({kk_o, nn_o}), 128'(0));
        reset = 1'b0;

        msg_q.delete();
        run_msg(0, 64, 0);                      // empty, unkeyed
        msg_q = '{8'h61, 8'h62, 8'h63};
        run_msg(0, 64, 2);                      // "abc"
        fill_msg(64);
        run_msg(0, 32, 0);                      // exactly one block
        fill_msg(65);
        run_msg(0, 64, 2);                      // one byte into a second block
        msg_q = '{8'h61, 8'h62, 8'h63};
        run_msg(32, 64, 2);                     // keyed "abc"
        fill_msg(10);
        run_msg(0, 20, 1);                      // stalls every other cycle
        msg_q.delete();
        run_msg(16, 48, 2);                     // keyed, empty message
        fill_msg(5);
        run_msg(100, 64, 0);                    // key length saturates
        msg_q.delete();
        run_msg(64, 64, 1);                     // full-block key, empty message
        fill_msg(130);
        run_msg(64, 40, 2);                     // full-block key, three message blocks
        for (int r = 0; r < 4; r++) begin
            fill_msg(int'($urandom_range(0, 150)));
            run_msg(int'($urandom_range(0, 70)), int'($urandom_range(1, 64)),
                    int'($urandom_range(0, 2)));
        end
        run_reset_mid();
        msg_q = '{8'h61, 8'h62, 8'h63};
        run_msg(0, 64, 0);                      // "abc" again after the abort

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
